// File: rtl/instruction_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_sequencer
//  Description : Fetch control stage. Owns the program counter, runs the
//                program-memory read handshake, loads the opcode byte into
//                IR_1 and an optional operand byte into IR_2, and traps
//                memory timeouts into a sticky error state.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_sequencer #(
    parameter int TWO_BYTE_BIT = 7,   // opcode bit flagging a two-byte instruction
    parameter int TIMEOUT      = 15   // FETCH cycles without ack before error (1..255)
) (
    input  logic       FS_clk,
    input  logic       FS_rst_n,
    input  logic       FS_start,
    input  logic       FS_pc_load,
    input  logic [7:0] FS_pc_in,
    output logic [7:0] FS_mem_addr,
    output logic       FS_mem_rd_en,
    input  logic [7:0] FS_mem_data,
    input  logic       FS_mem_ack,
    output logic       FS_IR_1_wr_en,
    output logic       FS_IR_2_wr_en,
    output logic [7:0] FS_IR_data,
    output logic [7:0] FS_pc,
    output logic       FS_busy,
    output logic       FS_done,
    output logic       FS_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    // Wait-counter value seen in the last cycle allowed before a timeout.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pc;
    logic [7:0] w_pc_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_next;
    logic       w_strobe;

    // State register; reset aborts any fetch in progress immediately.
    always_ff @(posedge FS_clk or negedge FS_rst_n) begin
        if (!FS_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter and consecutive-wait counter.
    always_ff @(posedge FS_clk or negedge FS_rst_n) begin
        if (!FS_rst_n) begin
            r_pc       <= 8'h00;
            r_wait_cnt <= 8'h00;
        end else begin
            r_pc       <= w_pc_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Next-state, next-PC, wait counting and the ack-qualified IR strobes.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_wait_next   = r_wait_cnt;
        FS_IR_1_wr_en = 1'b0;
        FS_IR_2_wr_en = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A PC load wins over a simultaneous start request.
                if (FS_pc_load) begin
                    w_pc_next = FS_pc_in;
                end else if (FS_start) begin
                    w_state_next = S_FETCH1;
                    w_wait_next  = 8'h00;
                end
            end

            S_FETCH1: begin
                if (FS_mem_ack) begin
                    FS_IR_1_wr_en = 1'b1;
                    w_pc_next     = r_pc + 8'd1;
                    if (FS_mem_data[TWO_BYTE_BIT]) begin
                        w_state_next = S_FETCH2;
                        w_wait_next  = 8'h00;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end else begin
                    // An ack in the final allowed cycle is taken above, so
                    // only a missing ack here trips the timeout.
                    w_wait_next = r_wait_cnt + 8'd1;
                    if (r_wait_cnt == c_wait_last) begin
                        w_state_next = S_ERROR;
                    end
                end
            end

            S_FETCH2: begin
                if (FS_mem_ack) begin
                    FS_IR_2_wr_en = 1'b1;
                    w_pc_next     = r_pc + 8'd1;
                    w_state_next  = S_DONE;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                    if (r_wait_cnt == c_wait_last) begin
                        w_state_next = S_ERROR;
                    end
                end
            end

            S_DONE: begin
                // Start is not looked at here; the requester must see IDLE.
                w_state_next = S_IDLE;
            end

            S_ERROR: begin
                // Only a PC load (or reset) releases the sticky error.
                if (FS_pc_load) begin
                    w_pc_next    = FS_pc_in;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_strobe = FS_IR_1_wr_en | FS_IR_2_wr_en;

    assign FS_mem_addr  = r_pc;
    assign FS_mem_rd_en = (r_state == S_FETCH1) || (r_state == S_FETCH2);
    assign FS_IR_data   = w_strobe ? FS_mem_data : 8'h00;
    assign FS_pc        = r_pc;
    assign FS_busy      = (r_state == S_FETCH1) || (r_state == S_FETCH2) ||
                          (r_state == S_DONE);
    assign FS_done      = (r_state == S_DONE);
    assign FS_error     = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_sequencer
//  Description : Scoreboard bench for instruction_fetch_sequencer. Directed
//                stimulus pushes expected IR writes, done pulses and error
//                onsets (with their cycle numbers); a monitor pops and
//                compares whenever the DUT presents one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_sequencer;

    logic       FS_clk;
    logic       FS_rst_n;
    logic       FS_start;
    logic       FS_pc_load;
    logic [7:0] FS_pc_in;
    logic [7:0] FS_mem_addr;
    logic       FS_mem_rd_en;
    logic [7:0] FS_mem_data;
    logic       FS_mem_ack;
    logic       FS_IR_1_wr_en;
    logic       FS_IR_2_wr_en;
    logic [7:0] FS_IR_data;
    logic [7:0] FS_pc;
    logic       FS_busy;
    logic       FS_done;
    logic       FS_error;

    instruction_fetch_sequencer #(.TWO_BYTE_BIT(7), .TIMEOUT(15)) dut (
        .FS_clk        (FS_clk),
        .FS_rst_n      (FS_rst_n),
        .FS_start      (FS_start),
        .FS_pc_load    (FS_pc_load),
        .FS_pc_in      (FS_pc_in),
        .FS_mem_addr   (FS_mem_addr),
        .FS_mem_rd_en  (FS_mem_rd_en),
        .FS_mem_data   (FS_mem_data),
        .FS_mem_ack    (FS_mem_ack),
        .FS_IR_1_wr_en (FS_IR_1_wr_en),
        .FS_IR_2_wr_en (FS_IR_2_wr_en),
        .FS_IR_data    (FS_IR_data),
        .FS_pc         (FS_pc),
        .FS_busy       (FS_busy),
        .FS_done       (FS_done),
        .FS_error      (FS_error)
    );

    localparam int K_IR1  = 1;
    localparam int K_IR2  = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         cyc;
    } ev_t;

    ev_t        sb[$];
    int         dly_q[$];
    logic [7:0] mem [256];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       ack_ok = 1'b0;
    logic       ack_stray = 1'b0;

    initial FS_clk = 1'b0;
    always #5 FS_clk = ~FS_clk;

    always @(posedge FS_clk) cyc <= cyc + 1;

    assign FS_mem_data = mem[FS_mem_addr];
    assign FS_mem_ack  = (FS_mem_rd_en & ack_ok) | ack_stray;

    // Memory responder: each request takes the next delay from dly_q;
    // an empty queue means the memory never answers.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge FS_clk);
            if (FS_mem_rd_en) begin
                if (dly_q.size() > 0) begin
                    if (cnt == dly_q[0]) begin
                        ack_ok <= 1'b1;
                        void'(dly_q.pop_front());
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            @(posedge FS_clk);
            ack_ok <= 1'b0;
        end
    end

    task automatic sb_compare(input int kind, input logic [7:0] val);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d val %h at cycle %0d, none expected",
                     kind, val, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL sb_event: got kind %0d val %h cycle %0d, expected kind %0d val %h cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: samples mid-cycle once the responder has settled.
    initial begin
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge FS_clk);
            #2;
            if (FS_rst_n) begin
                if (FS_IR_1_wr_en) sb_compare(K_IR1, FS_IR_data);
                if (FS_IR_2_wr_en) sb_compare(K_IR2, FS_IR_data);
                if (FS_done)       sb_compare(K_DONE, FS_pc);
                if (FS_error && !prev_err) sb_compare(K_ERR, FS_pc);
                prev_err = FS_error;
            end else begin
                prev_err = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge FS_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] val, input int at);
        sb.push_back('{kind: kind, val: val, cyc: at});
    endtask

    // Pulse start for one cycle; s is the cycle in which start is sampled,
    // so the first FETCH1 cycle is s+1.
    task automatic pulse_start(output int s);
        s = cyc;
        FS_start = 1'b1;
        tick();
        FS_start = 1'b0;
    endtask

    task automatic load_pc(input logic [7:0] v);
        FS_pc_in   = v;
        FS_pc_load = 1'b1;
        tick();
        FS_pc_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        FS_rst_n   = 1'b0;
        FS_start   = 1'b0;
        FS_pc_load = 1'b0;
        FS_pc_in   = 8'h00;

        // Reset values
        #12;
        check("rst_mem_addr", FS_mem_addr, 8'h00);
        check("rst_rd_en",    {7'd0, FS_mem_rd_en}, 8'h00);
        check("rst_ir1_wr",   {7'd0, FS_IR_1_wr_en}, 8'h00);
        check("rst_ir2_wr",   {7'd0, FS_IR_2_wr_en}, 8'h00);
        check("rst_ir_data",  FS_IR_data, 8'h00);
        check("rst_pc",       FS_pc, 8'h00);
        check("rst_busy",     {7'd0, FS_busy}, 8'h00);
        check("rst_done",     {7'd0, FS_done}, 8'h00);
        check("rst_error",    {7'd0, FS_error}, 8'h00);
        tick();
        FS_rst_n = 1'b1;
        tick();

        // One-byte fetch, zero wait, plus a start held during DONE
        mem[8'h00] = 8'h12;
        dly_q.push_back(0);
        expect_ev(K_IR1, 8'h12, cyc + 1);
        expect_ev(K_DONE, 8'h01, cyc + 2);
        pulse_start(s);
        tick();                      // DONE cycle
        FS_start = 1'b1;
        tick();                      // back in IDLE, start rejected
        FS_start = 1'b0;
        check("b2b_rd_en", {7'd0, FS_mem_rd_en}, 8'h00);
        tick();
        check("b2b_busy", {7'd0, FS_busy}, 8'h00);
        check("pc_after_1byte", FS_pc, 8'h01);

        // Two-byte fetch, zero wait
        mem[8'h01] = 8'h85;
        mem[8'h02] = 8'h3C;
        dly_q.push_back(0);
        dly_q.push_back(0);
        expect_ev(K_IR1, 8'h85, cyc + 1);
        expect_ev(K_IR2, 8'h3C, cyc + 2);
        expect_ev(K_DONE, 8'h03, cyc + 3);
        pulse_start(s);
        repeat (4) tick();
        check("pc_after_2byte", FS_pc, 8'h03);

        // Wait states: 3 in FETCH1, 2 in FETCH2
        mem[8'h03] = 8'h9A;
        mem[8'h04] = 8'h55;
        dly_q.push_back(3);
        dly_q.push_back(2);
        expect_ev(K_IR1, 8'h9A, cyc + 4);
        expect_ev(K_IR2, 8'h55, cyc + 7);
        expect_ev(K_DONE, 8'h05, cyc + 8);
        pulse_start(s);
        for (int i = 1; i <= 7; i++) begin
            check("wait_rd_en", {7'd0, FS_mem_rd_en}, 8'h01);
            check("wait_addr", FS_mem_addr, (i <= 4) ? 8'h03 : 8'h04);
            tick();
        end
        repeat (2) tick();
        check("pc_after_wait", FS_pc, 8'h05);

        // Stray ack while idle must produce nothing
        ack_stray = 1'b1;
        repeat (2) tick();
        ack_stray = 1'b0;
        check("stray_pc", FS_pc, 8'h05);

        // Timeout: memory never answers
        mem[8'h05] = 8'h01;
        expect_ev(K_ERR, 8'h05, cyc + 16);
        pulse_start(s);
        repeat (16) tick();
        check("to_error", {7'd0, FS_error}, 8'h01);
        check("to_rd_en", {7'd0, FS_mem_rd_en}, 8'h00);
        check("to_busy",  {7'd0, FS_busy}, 8'h00);
        FS_start = 1'b1;
        repeat (2) tick();
        FS_start = 1'b0;
        check("to_start_ignored_err", {7'd0, FS_error}, 8'h01);
        check("to_start_ignored_rd",  {7'd0, FS_mem_rd_en}, 8'h00);
        check("to_pc_held", FS_pc, 8'h05);
        load_pc(8'h40);
        check("rec_error", {7'd0, FS_error}, 8'h00);
        check("rec_pc", FS_pc, 8'h40);
        check("rec_busy", {7'd0, FS_busy}, 8'h00);

        // Ack on the 15th cycle is a normal fetch
        mem[8'h40] = 8'h07;
        dly_q.push_back(14);
        expect_ev(K_IR1, 8'h07, cyc + 15);
        expect_ev(K_DONE, 8'h41, cyc + 16);
        pulse_start(s);
        repeat (17) tick();
        check("edge15_error", {7'd0, FS_error}, 8'h00);
        check("edge15_pc", FS_pc, 8'h41);

        // PC wrap: two-byte opcode at FF, operand from 00
        load_pc(8'hFF);
        mem[8'hFF] = 8'hC3;
        dly_q.push_back(0);
        dly_q.push_back(0);
        expect_ev(K_IR1, 8'hC3, cyc + 1);
        expect_ev(K_IR2, 8'h12, cyc + 2);
        expect_ev(K_DONE, 8'h01, cyc + 3);
        pulse_start(s);
        repeat (4) tick();
        check("wrap_pc", FS_pc, 8'h01);

        // pc_load and start together in IDLE
        FS_pc_in   = 8'h20;
        FS_pc_load = 1'b1;
        FS_start   = 1'b1;
        tick();
        FS_pc_load = 1'b0;
        FS_start   = 1'b0;
        check("prio_pc", FS_pc, 8'h20);
        check("prio_rd_en", {7'd0, FS_mem_rd_en}, 8'h00);
        check("prio_busy", {7'd0, FS_busy}, 8'h00);

        // Reset during FETCH2
        mem[8'h20] = 8'h81;
        mem[8'h21] = 8'h66;
        dly_q.push_back(0);
        dly_q.push_back(5);
        expect_ev(K_IR1, 8'h81, cyc + 1);
        pulse_start(s);
        repeat (2) tick();
        check("mid_in_fetch2_addr", FS_mem_addr, 8'h21);
        FS_rst_n = 1'b0;
        #1;
        dly_q.delete();
        check("mid_rst_rd_en", {7'd0, FS_mem_rd_en}, 8'h00);
        check("mid_rst_pc", FS_pc, 8'h00);
        check("mid_rst_addr", FS_mem_addr, 8'h00);
        check("mid_rst_busy", {7'd0, FS_busy}, 8'h00);
        check("mid_rst_ir2", {7'd0, FS_IR_2_wr_en}, 8'h00);
        check("mid_rst_data", FS_IR_data, 8'h00);
        tick();
        FS_rst_n = 1'b1;
        tick();
        check("post_rst_pc", FS_pc, 8'h00);

        // Normal fetch after reset
        dly_q.push_back(0);
        expect_ev(K_IR1, 8'h12, cyc + 1);
        expect_ev(K_DONE, 8'h01, cyc + 2);
        pulse_start(s);
        repeat (4) tick();
        check("final_pc", FS_pc, 8'h01);

        check("sb_drained", 8'(sb.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
